binary_counter_param: RTL and testbench

Parametrised next-generation binary counter for the counter/timer datapath.
- Configurable width, up/down direction, wrap or saturate mode, and programmable modulo limit.
- Has a built-in prescaler, synchronous clear and load, and a compare match output.
- Flags boundary events with a terminal-count pulse and a sticky overflow flag.
- Drives timer/event logic downstream; its inputs come from control registers.

---
 rtl/binary_counter_param.sv | 89 ++++++++
 tb/tb_binary_counter_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/binary_counter_param.sv
// Parametrised up/down counter with prescaler, modulo limit, wrap/saturate
// boundary handling, compare match and sticky overflow.
module binary_counter_param #(
  parameter int WIDTH = 6,
  parameter int PRE_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             ovf,
  output logic             cmp_match
);

  logic [PRE_W-1:0] pre_cnt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             step_due;

  // >= rather than == so a prescale lowered below pre_cnt still fires next cycle
  assign step_due     = (pre_cnt >= prescale);
  assign load_clamped = (load_val > limit) ? limit : load_val;
  assign cmp_match    = (count == cmp_val);

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (up) begin
      if (count >= limit) begin
        count_nxt = sat ? limit : '0;
        tc_nxt    = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end else begin
      if (count > limit) begin
        count_nxt = limit;
      end else if (count != '0) begin
        count_nxt = count - 1'b1;
      end else begin
        count_nxt = sat ? '0 : limit;
        tc_nxt    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      count   <= load_clamped;
      pre_cnt <= '0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (en && step_due) begin
      count   <= count_nxt;
      pre_cnt <= '0;
      tick    <= 1'b1;
      tc      <= tc_nxt;
      ovf     <= ovf | tc_nxt;
    end else begin
      if (en) pre_cnt <= pre_cnt + 1'b1;
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_binary_counter_param.sv
// Directed self-checking bench for binary_counter_param (WIDTH=6, PRE_W=8).
module tb_binary_counter_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       en, up, sat, clear, load;
  logic [5:0] load_val, limit, cmp_val;
  logic [7:0] prescale;
  logic [5:0] count;
  logic       tick, tc, ovf, cmp_match;

  int n_checks = 0;
  int n_fail   = 0;

  binary_counter_param #(.WIDTH(6), .PRE_W(8)) dut (
    .clock(clock), .reset(reset), .en(en), .up(up), .sat(sat),
    .clear(clear), .load(load), .load_val(load_val), .limit(limit),
    .prescale(prescale), .cmp_val(cmp_val), .count(count), .tick(tick),
    .tc(tc), .ovf(ovf), .cmp_match(cmp_match)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input int c, input int tk, input int t, input int o);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tick"},  32'(tick),  32'(tk));
    check({tag, ".tc"},    32'(tc),    32'(t));
    check({tag, ".ovf"},   32'(ovf),   32'(o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; clear = 1'b0; load = 1'b0;
    load_val = '0; limit = 6'd63; prescale = 8'd0; cmp_val = 6'd63;
    #2;
    check_state("por", 0, 0, 0, 0);
    step_clk();
    step_clk();
    reset = 1'b0;
    en = 1'b1;

    // reset asserted between edges at count=17
    for (int i = 1; i <= 17; i++) step_clk();
    check_state("run17", 17, 1, 0, 0);
    #2 reset = 1'b1;
    #1 check_state("async_rst", 0, 0, 0, 0);
    step_clk();
    check("rst_held.count", 32'(count), 32'd0);
    reset = 1'b0;
    step_clk();
    check_state("resume1", 1, 1, 0, 0);
    step_clk();
    check_state("resume2", 2, 1, 0, 0);

    // up wrap at limit=5
    limit = 6'd5; clear = 1'b1;
    step_clk();
    clear = 1'b0;
    check_state("wrap_clr", 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step_clk();
      check_state($sformatf("wrap%0d", i), i % 6, 1, (i == 6) ? 1 : 0, (i == 6) ? 1 : 0);
    end
    step_clk();
    check_state("wrap7", 1, 1, 0, 1);

    // down saturate from 2
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
    check_state("dsat_clr", 0, 0, 0, 0);
    load = 1'b1; load_val = 6'd2;
    step_clk();
    load = 1'b0; up = 1'b0; sat = 1'b1;
    check_state("dsat_load", 2, 0, 0, 0);
    step_clk(); check_state("dsat1", 1, 1, 0, 0);
    step_clk(); check_state("dsat0", 0, 1, 0, 0);
    step_clk(); check_state("dsat_clamp1", 0, 1, 1, 1);
    step_clk(); check_state("dsat_clamp2", 0, 1, 1, 1);
    clear = 1'b1;
    step_clk();
    clear = 1'b0;
    check_state("dsat_clear", 0, 0, 0, 0);

    // prescaler: step every 4th enabled cycle
    up = 1'b1; sat = 1'b0; limit = 6'd63; prescale = 8'd3;
    for (int i = 1; i <= 8; i++) begin
      step_clk();
      check($sformatf("pre%0d.count", i), 32'(count), 32'(i / 4));
      check($sformatf("pre%0d.tick", i), 32'(tick), (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    step_clk();
    en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step_clk();
      check_state($sformatf("freeze%0d", i), 2, 0, 0, 0);
    end
    en = 1'b1;
    step_clk();
    check_state("resume_pre2", 2, 0, 0, 0);
    prescale = 8'd1;
    step_clk();
    check_state("pre_lowered", 3, 1, 0, 0);
    step_clk();
    check_state("pre1_a", 3, 0, 0, 0);
    step_clk();
    check_state("pre1_b", 4, 1, 0, 0);

    // simultaneous controls, step due every cycle
    prescale = 8'd0;
    clear = 1'b1; load = 1'b1; load_val = 6'd10;
    step_clk();
    clear = 1'b0;
    check_state("clr_vs_load", 0, 0, 0, 0);
    load_val = 6'd50; limit = 6'd40;
    step_clk();
    check_state("load_clamp", 40, 0, 0, 0);
    load_val = 6'd7;
    step_clk();
    load = 1'b0;
    check_state("load_vs_step", 7, 0, 0, 0);

    // compare and runtime limit changes
    limit = 6'd63; load = 1'b1; load_val = 6'd30; cmp_val = 6'd30; en = 1'b0;
    step_clk();
    load = 1'b0;
    check("cmp_hit", 32'(cmp_match), 32'd1);
    cmp_val = 6'd31;
    #1 check("cmp_miss", 32'(cmp_match), 32'd0);
    limit = 6'd20; up = 1'b1; en = 1'b1;
    step_clk();
    en = 1'b0;
    check_state("lim_up_wrap", 0, 1, 1, 1);
    limit = 6'd63; load = 1'b1;
    step_clk();
    load = 1'b0;
    check("reload30", 32'(count), 32'd30);
    limit = 6'd20; up = 1'b0; en = 1'b1;
    step_clk();
    check_state("lim_down", 20, 1, 0, 1);

    // limit=0 and saturate at limit going up
    limit = 6'd0; clear = 1'b1;
    step_clk();
    clear = 1'b0; up = 1'b1;
    step_clk();
    check_state("lim0_up", 0, 1, 1, 1);
    up = 1'b0;
    step_clk();
    check_state("lim0_down", 0, 1, 1, 1);
    limit = 6'd40; load = 1'b1; load_val = 6'd40; up = 1'b1; sat = 1'b1;
    step_clk();
    load = 1'b0;
    step_clk();
    check_state("sat_up", 40, 1, 1, 1);
    step_clk();
    check_state("sat_up2", 40, 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
